// File: rtl/icap_sequencer.sv
// icap_sequencer: buffers ICAP write words in a small FIFO, streams them to the
// ICAPE2 pins one per cycle, and sequences CSIB/RDWRB for single-word readback.
// Build option: define ICAP_BITSWAP_EN to reverse the bits within each byte on
// icap_i and on icap_o before capture (Xilinx ICAP bit ordering). Without it,
// data passes straight through and bitstreams must be pre-swapped in software.
module icap_sequencer #(
    parameter int unsigned BUS_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RDWR_TURN  = 2,
    parameter int unsigned RD_LAT     = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 write_req,
    input  logic                 read_req,
    input  logic [BUS_WIDTH-1:0] icap_wrdata,
    output logic                 icap_busy,
    output logic                 icap_csib,
    output logic                 icap_rdwrb,
    output logic [BUS_WIDTH-1:0] icap_i,
    input  logic [BUS_WIDTH-1:0] icap_o,
    output logic [BUS_WIDTH-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 overflow
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_MAX = (RDWR_TURN > RD_LAT) ? RDWR_TURN : RD_LAT;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] TURN_LAST = CW'(RDWR_TURN - 1);
    localparam logic [CW-1:0] RD_LAST   = CW'(RD_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
    // Fill level at which fewer than two entries remain free.
    localparam logic [AW:0]   BUSY_FILL = (AW+1)'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_TURN,
        S_READ,
        S_TURN_BACK
    } state_t;

    state_t state, state_next;
    logic [CW-1:0] cnt, cnt_next;

    logic [BUS_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr, fill;
    logic                 fifo_empty, fifo_full;
    logic                 push, pop;

    logic                 read_pending;
    logic                 csib_next, rdwrb_next, capture;
    logic [BUS_WIDTH-1:0] wr_word, rd_word;

`ifdef ICAP_BITSWAP_EN
    function automatic logic [BUS_WIDTH-1:0] swap_in_bytes(input logic [BUS_WIDTH-1:0] d);
        logic [BUS_WIDTH-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < BUS_WIDTH / 8; b++) begin
            for (int unsigned k = 0; k < 8; k++) begin
                r[b*8 + k] = d[b*8 + 7 - k];
            end
        end
        return r;
    endfunction

    assign wr_word = swap_in_bytes(mem[rd_ptr[AW-1:0]]);
    assign rd_word = swap_in_bytes(icap_o);
`else
    assign wr_word = mem[rd_ptr[AW-1:0]];
    assign rd_word = icap_o;
`endif

    assign fill       = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    // A full FIFO drops the word even if a pop frees an entry on the same edge.
    assign push       = write_req && !fifo_full;

    assign icap_busy = (fill >= BUSY_FILL) || read_pending ||
                       !((state == S_IDLE) || (state == S_WRITE));

    // FIFO pointers and sticky overflow flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (write_req && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are meaningless after reset since the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= icap_wrdata;
        end
    end

    // Read request flag; a request arriving on the capture edge stays pending.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            read_pending <= 1'b0;
        end else begin
            read_pending <= (read_pending && !capture) || read_req;
        end
    end

    // FSM state and phase counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: writes drain before a pending read starts its turnaround.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_next = S_WRITE;
                end else if (read_pending) begin
                    state_next = S_TURN;
                    cnt_next   = '0;
                end
            end
            S_WRITE: begin
                if (fifo_empty) begin
                    state_next = S_IDLE;
                end
            end
            S_TURN: begin
                if (cnt == TURN_LAST) begin
                    state_next = S_READ;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            S_READ: begin
                if (cnt == RD_LAST) begin
                    state_next = S_TURN_BACK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            S_TURN_BACK: begin
                if (cnt == TURN_LAST) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output decode: values computed here appear on the pins after the edge,
    // so RDWRB only toggles on edges where CSIB stays high.
    always_comb begin
        pop        = 1'b0;
        capture    = 1'b0;
        csib_next  = icap_csib;
        rdwrb_next = icap_rdwrb;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    csib_next = 1'b0;
                end else if (read_pending) begin
                    csib_next  = 1'b1;
                    rdwrb_next = 1'b1;
                end
            end
            S_WRITE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    csib_next = 1'b0;
                end else begin
                    csib_next = 1'b1;
                end
            end
            S_TURN: begin
                rdwrb_next = 1'b1;
                csib_next  = (cnt == TURN_LAST) ? 1'b0 : 1'b1;
            end
            S_READ: begin
                if (cnt == RD_LAST) begin
                    capture   = 1'b1;
                    csib_next = 1'b1;
                end else begin
                    csib_next = 1'b0;
                end
            end
            S_TURN_BACK: begin
                csib_next = 1'b1;
                if (cnt == TURN_LAST) begin
                    rdwrb_next = 1'b0;
                end
            end
            default: begin
                csib_next  = 1'b1;
                rdwrb_next = 1'b0;
            end
        endcase
    end

    // Registered ICAP pins and readback outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            icap_csib  <= 1'b1;
            icap_rdwrb <= 1'b0;
            icap_i     <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            icap_csib  <= csib_next;
            icap_rdwrb <= rdwrb_next;
            rd_valid   <= capture;
            if (pop) begin
                icap_i <= wr_word;
            end
            if (capture) begin
                rd_data <= rd_word;
            end
        end
    end

endmodule

// File: doc/icap_sequencer.md
Name: icap_sequencer

Overview:
- Downstream stage of the ICAP register interface; consumes its write_req/read_req/icap_wrdata strobes and drives the ICAPE2 primitive pins.
- Buffers write words in a small FIFO and streams them one per cycle to ICAP.
- Sequences the CSIB/RDWRB protocol for single-word readback.
- Returns icap_busy to the interface for flow control.

Parameters:
- BUS_WIDTH, 32, ICAP data width; legal values 8, 16, 32.
- FIFO_DEPTH, 4, write buffer entries; power of two, at least 2.
- RDWR_TURN, 2, cycles with CSIB high around each RDWRB direction change; at least 1.
- RD_LAT, 3, cycles CSIB is held low in read before icap_o is sampled; at least 1.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- write_req  in  1  one-cycle strobe; push icap_wrdata
- read_req  in  1  one-cycle strobe; perform one ICAP read
- icap_wrdata  in  BUS_WIDTH  write word
- icap_busy  out  1  upstream must not issue requests while high
- icap_csib  out  1  ICAP chip select, active low
- icap_rdwrb  out  1  ICAP direction; 0 = write, 1 = read
- icap_i  out  BUS_WIDTH  ICAP write data
- icap_o  in  BUS_WIDTH  ICAP read data
- rd_data  out  BUS_WIDTH  captured readback word
- rd_valid  out  1  one-cycle pulse; rd_data is new
- overflow  out  1  sticky; a write was dropped because the FIFO was full

Behaviour:
- Reset values: icap_csib=1, icap_rdwrb=0, icap_i=0, rd_data=0, rd_valid=0, overflow=0. FIFO empty, read-pending flag clear, FSM in IDLE. Reset asserted mid-operation aborts immediately and discards FIFO contents.
- All outputs except icap_busy are registered. icap_busy is combinational from registers: (free entries < 2) OR read_pending OR FSM not in {IDLE, WRITE}. The threshold of 2 leaves one entry of slack for the upstream's registered request.
- write_req pushes on the same edge. If the FIFO is full, the word is dropped and overflow sets; only reset clears overflow.
- read_req sets read_pending. A second read_req while read_pending is set is merged (no effect).
- FSM:
  - IDLE: FIFO non-empty -> pop, drive icap_i, icap_csib=0, go to WRITE. Else, read_pending -> icap_csib=1, go to TURN.
  - WRITE: FIFO non-empty -> pop and drive, one word per cycle. Empty -> icap_csib=1, go to IDLE.
  - TURN: icap_rdwrb=1, icap_csib=1 for RDWR_TURN cycles, then -> READ.
  - READ: icap_csib=0 for RD_LAT cycles. On the last cycle, capture icap_o into rd_data, pulse rd_valid, clear read_pending -> TURN_BACK.
  - TURN_BACK: icap_csib=1 for RDWR_TURN cycles, then icap_rdwrb=0 -> IDLE.
- icap_rdwrb never changes while icap_csib=0.
- Write latency: word pushed at edge N appears on icap_i with icap_csib=0 after edge N+1 (FSM in IDLE or WRITE).
- Writes take priority: a pending read is served only after the FIFO drains.
- Writes pushed during TURN/READ/TURN_BACK wait in the FIFO.
- Simultaneous write_req and read_req: the word is pushed and the read stays pending; the word is sent first.
- FIFO pointers wrap modulo FIFO_DEPTH, with an extra bit to distinguish full from empty.

Optional Feature:
- Macro: ICAP_BITSWAP_EN.
- Defined: bits are reversed within each byte on icap_i (FIFO output) and on icap_o before capture, so the Xilinx ICAP bit ordering is handled here.
- Undefined: data passes straight through. Bitstreams must then be pre-swapped by software.

Test Plan:
- Reset, then write_req with 0xAA995566 -> after next edge icap_csib=0, icap_rdwrb=0, icap_i=0xAA995566 for exactly one cycle, then icap_csib=1.
- 4 back-to-back writes 0x1..0x4 -> icap_i shows 0x1,0x2,0x3,0x4 on consecutive cycles with icap_csib low for 4 cycles. icap_busy rises when free entries < 2.
- With FIFO full, force write_req 0xDEADBEEF -> word never appears on icap_i and overflow=1 until rstn.
- read_req with icap_o=0x12345678 -> RDWR_TURN=2 cycles CSIB=1/RDWRB=1, then 3 cycles CSIB=0, then rd_valid pulse with rd_data=0x12345678, then 2 cycles CSIB=1, then RDWRB=0. Bitswap build expects 0x482C6A1E.
- write_req 0x5 and read_req on the same cycle -> 0x5 written first, then the read sequence. icap_busy stays high until TURN_BACK completes.
- rstn low during READ -> icap_csib=1, icap_rdwrb=0, rd_valid never pulses, FIFO empty, icap_busy=0 after release.
